// File: rtl/rat_stack_unit_pkg.sv
// Shared types and helpers for the stack-pointer / scratch-RAM unit.
package rat_stack_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LD   = 3'd1,
        ST   = 3'd2,
        PUSH = 3'd3,
        POP  = 3'd4,
        SPLD = 3'd5,
        SPRD = 3'd6
    } stack_op_t;

    // Number of words between STACK_LIMIT and the top of memory.
    function automatic int stack_depth(input int addr_w, input int limit);
        return (1 << addr_w) - limit;
    endfunction

endpackage

// File: rtl/rat_stack_unit_if.sv
// Request/response handshake between the control unit and the stack unit.
interface rat_stack_unit_if
    import rat_stack_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    stack_op_t         req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rat_scratch_mem.sv
// Single-port synchronous scratch RAM with a registered read port.
module rat_scratch_mem #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data only moves on a read, so a stalled response stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/rat_stack_unit.sv
// Stack pointer, occupancy tracking, sticky errors and a single-entry response
// register wrapped around the scratch RAM.
module rat_stack_unit
    import rat_stack_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int ADDR_W      = 8,
    parameter int STACK_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    rat_stack_unit_if.slave   bus,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_spld
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(stack_depth(ADDR_W, STACK_LIMIT));
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(STACK_LIMIT);
    localparam logic [ADDR_W:0] SPAN  = {1'b1, {ADDR_W{1'b0}}};

    logic              accept;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] sp_d;
    logic [ADDR_W:0]   count_d;
    logic              rsp_gen, rsp_sel_sp, rsp_sel_sp_d;
    logic [ADDR_W-1:0] rsp_sp;
    logic              ovf_ev, unf_ev, spld_ev;
    logic [ADDR_W:0]   spld_diff;
    logic              spld_legal;

    assign empty         = (count == '0);
    assign full          = (count == DEPTH);
    assign bus.req_ready = !(bus.rsp_valid && !bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_rdata = rsp_sel_sp ? DATA_W'(rsp_sp) : mem_rdata;

    // The borrow out of (v - STACK_LIMIT) marks an SP load below the stack region.
    assign spld_diff  = {1'b0, bus.req_addr} - LIMIT;
    assign spld_legal = (bus.req_addr == '0) || !spld_diff[ADDR_W];

    always_comb begin
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = bus.req_addr;
        sp_d         = sp;
        count_d      = count;
        rsp_gen      = 1'b0;
        rsp_sel_sp_d = rsp_sel_sp;
        ovf_ev       = 1'b0;
        unf_ev       = 1'b0;
        spld_ev      = 1'b0;
        if (accept) begin
            case (bus.req_op)
                LD: begin
                    mem_en       = 1'b1;
                    rsp_gen      = 1'b1;
                    rsp_sel_sp_d = 1'b0;
                end
                ST: begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                end
                PUSH: begin
                    if (full) begin
                        ovf_ev = 1'b1;
                    end else begin
                        mem_en   = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = sp - ADDR_W'(1);
                        sp_d     = sp - ADDR_W'(1);
                        count_d  = count + (ADDR_W+1)'(1);
                    end
                end
                POP: begin
                    if (empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        mem_en       = 1'b1;
                        mem_addr     = sp;
                        sp_d         = sp + ADDR_W'(1);
                        count_d      = count - (ADDR_W+1)'(1);
                        rsp_gen      = 1'b1;
                        rsp_sel_sp_d = 1'b0;
                    end
                end
                SPLD: begin
                    if (spld_legal) begin
                        sp_d    = bus.req_addr;
                        count_d = (bus.req_addr == '0) ? '0 : SPAN - {1'b0, bus.req_addr};
                    end else begin
                        spld_ev = 1'b1;
                    end
                end
                SPRD: begin
                    rsp_gen      = 1'b1;
                    rsp_sel_sp_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Error events are applied after the clear so a coinciding error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp            <= '0;
            count         <= '0;
            bus.rsp_valid <= 1'b0;
            rsp_sel_sp    <= 1'b0;
            rsp_sp        <= '0;
            err_ovf       <= 1'b0;
            err_unf       <= 1'b0;
            err_spld      <= 1'b0;
        end else begin
            sp            <= sp_d;
            count         <= count_d;
            bus.rsp_valid <= rsp_gen || (bus.rsp_valid && !bus.rsp_ready);
            rsp_sel_sp    <= rsp_sel_sp_d;
            if (rsp_gen) begin
                rsp_sp <= sp;
            end
            err_ovf  <= ovf_ev  || (err_ovf  && !err_clr);
            err_unf  <= unf_ev  || (err_unf  && !err_clr);
            err_spld <= spld_ev || (err_spld && !err_clr);
        end
    end

    rat_scratch_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus.req_wdata),
        .rdata (mem_rdata)
    );
endmodule

// File: doc/rat_stack_unit.md
Name: rat_stack_unit

Overview:
- Parametrised successor to the MCU's stack-pointer plus scratch-RAM pair. It merges both into one unit behind a single request/response handshake.
- Adds the following on top of the plain SP/scratch pair:
  - configurable data width and depth
  - a protected stack region with occupancy tracking
  - sticky overflow/underflow/SP-load error flags
  - response backpressure
- Sits between the control unit and the register file/PC mux. It serves direct LD/ST, PUSH/POP (including CALL/RET/interrupt frames) and SP load/read.

Parameters:
- DATA_W, 10, word width; must be ≥ the PC width for CALL frames.
- ADDR_W, 8, address width; memory holds 2**ADDR_W words.
- STACK_LIMIT, 0, lowest address the stack may occupy. Stack depth = 2**ADDR_W − STACK_LIMIT.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous reset, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  unit accepts a request this cycle
- REQ_OP  in  3  operation code (stack_op_t)
- REQ_ADDR  in  ADDR_W  address for LD/ST; new SP value for SPLD
- REQ_WDATA  in  DATA_W  write data for ST/PUSH
- RSP_VALID  out  1  read data valid
- RSP_READY  in  1  consumer takes the response
- RSP_RDATA  out  DATA_W  read data
- SP  out  ADDR_W  current stack pointer
- COUNT  out  ADDR_W+1  words on stack
- EMPTY  out  1  COUNT==0
- FULL  out  1  COUNT==depth
- ERR_OVF  out  1  sticky: PUSH while FULL
- ERR_UNF  out  1  sticky: POP while EMPTY
- ERR_SPLD  out  1  sticky: SPLD outside the stack region
- ERR_CLR  in  1  clears all sticky errors

Behaviour:
- Reset (async on RST_N low):
  - SP=0, COUNT=0, EMPTY=1, FULL=0
  - RSP_VALID=0, RSP_RDATA=0, all ERR_*=0
  - memory contents are undefined
  - an in-flight response is discarded
- Accept condition: a request is accepted when REQ_VALID && REQ_READY. REQ_READY = !(RSP_VALID && !RSP_READY), so one outstanding response is allowed.
- NOP: no effect.
- ST: mem[REQ_ADDR] <= REQ_WDATA. No response is generated. SP and COUNT are unchanged.
- LD: synchronous read. RSP_VALID rises the cycle after acceptance with RSP_RDATA = mem[REQ_ADDR]. The response holds until RSP_READY.
- PUSH (stack grows downward):
  - addr = SP−1 mod 2**ADDR_W, mem[addr] <= REQ_WDATA, SP <= addr, COUNT+1.
  - If FULL: no write, SP/COUNT unchanged, ERR_OVF <= 1.
- POP:
  - read mem[SP], SP <= SP+1 mod 2**ADDR_W, COUNT−1. Response one cycle later.
  - If EMPTY: no read, no response, SP unchanged, ERR_UNF <= 1.
- SPLD:
  - v = REQ_ADDR.
  - Legal if v==0 or v ≥ STACK_LIMIT. Then SP <= v and COUNT <= (v==0 ? 0 : 2**ADDR_W − v).
  - Otherwise ERR_SPLD <= 1 and SP/COUNT are unchanged.
- SPRD: response one cycle later with RSP_RDATA = SP zero-extended.
- Hazards:
  - POP accepted the cycle after PUSH returns the pushed word (write precedes read).
  - LD after ST to the same address returns the new data.
- ERR_CLR: clears the sticky flags. If ERR_CLR coincides with an error event, the error wins.
- Protected region: LD/ST are not checked against the stack region. The software owns aliasing.
- Ordering: responses are returned in request order. At most one response is pending.

Decomposition:
- Package rat_stack_pkg:
  - stack_op_t enum: NOP=0, LD=1, ST=2, PUSH=3, POP=4, SPLD=5, SPRD=6; 7 reserved, behaves as NOP.
  - Depth helper function.
- Sub-module rat_scratch_mem: single-port synchronous RAM, parameters DATA_W and ADDR_W, write-enable, registered read. The top holds the SP/COUNT/error logic and the response register.

Test Plan:
- Reset then PUSH 0x155, 0x2AA -> SP=0xFE, COUNT=2. Then POP, POP -> RSP_RDATA 0x2AA then 0x155. Final SP=0, EMPTY=1.
- STACK_LIMIT=0xFC (depth 4): push 5 words -> the 5th sets ERR_OVF=1, SP stays 0xFC, COUNT=4, FULL=1. ERR_CLR -> ERR_OVF=0.
- POP from reset -> ERR_UNF=1, RSP_VALID stays 0, SP=0.
- LD with RSP_READY held low 3 cycles -> REQ_READY=0 during the stall, RSP_RDATA stable. A queued ST is accepted only after the handshake completes.
- SPLD 0x80 (STACK_LIMIT=0xFC) -> ERR_SPLD=1, SP unchanged. SPLD 0xFE -> SP=0xFE, COUNT=2. SPRD -> 0x0FE.
- Pull RST_N low mid-LD (RSP_VALID=1) -> RSP_VALID=0, SP=0, COUNT=0 immediately, without waiting for a clock edge.
